// File: rtl/serial_frame_rx.sv
// Strobed serial-to-parallel frame receiver (start, WIDTH data bits, stop); word visible one cycle after the stop strobe.
// Output is a single valid/ready slot: a good frame arriving while the slot is full and not being consumed is dropped with an overrun pulse.
module serial_frame_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_din,
    input  logic             s_en,
    input  logic             msb_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             order_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            order_msb  <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // A load in the STOP branch below overrides this clear.
            if (dout_valid && dout_ready)
                dout_valid <= 1'b0;

            if (s_en) begin
                case (state)
                    IDLE: begin
                        if (!s_din) begin
                            order_msb <= msb_first;
                            bit_cnt   <= '0;
                            state     <= DATA;
                            busy      <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (order_msb)
                            shreg <= {shreg[WIDTH-2:0], s_din};
                        else
                            shreg <= {s_din, shreg[WIDTH-1:1]};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(WIDTH - 1))
                            state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!s_din) begin
                            frame_err <= 1'b1;
                        end else if (!dout_valid || dout_ready) begin
                            dout       <= shreg;
                            dout_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: drives frames bit by bit and checks outputs against hand-computed values.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_din = 1'b1;
    logic       s_en = 1'b0;
    logic       msb_first = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_err = 0;
    bit busy_ok;

    serial_frame_rx #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_din      (s_din),
        .s_en       (s_en),
        .msb_first  (msb_first),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic send_bit(input logic b, input int gap);
        s_din = b;
        s_en  = 1'b1;
        @(posedge clk);
        #1;
        s_en  = 1'b0;
        s_din = 1'b1;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    // Returns 1 ns after the stop-bit edge; busy_ok records busy=1 after start and every data bit.
    task automatic send_frame(input logic [7:0] w, input logic msb, input logic stop_b,
                              input int gap, input logic rdy_on_stop);
        logic b;
        msb_first = msb;
        busy_ok   = 1'b1;
        send_bit(1'b0, gap);
        if (busy !== 1'b1) busy_ok = 1'b0;
        msb_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = msb ? w[7-i] : w[i];
            send_bit(b, (i == 7) ? 0 : gap);
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        dout_ready = rdy_on_stop;
        send_bit(stop_b, 0);
        dout_ready = 1'b0;
    endtask

    task automatic consume();
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++; if ({dout_valid, busy, frame_err, overrun} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {dout_valid, busy, frame_err, overrun}); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_lsb_first();
        send_frame(8'hB5, 1'b0, 1'b1, 0, 1'b0);
        n_cmp++; if (busy_ok !== 1'b1) begin n_err++; $display("FAIL lsb_busy_frame: got %b want 1", busy_ok); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL lsb_busy_after: got %b want 0", busy); end
        n_cmp++; if (dout !== 8'hB5) begin n_err++; $display("FAIL lsb_dout: got %h want b5", dout); end
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL lsb_valid: got %b want 1", dout_valid); end
        consume();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL lsb_consume: got %b want 0", dout_valid); end
    endtask

    task automatic test_msb_gapped();
        send_frame(8'hAD, 1'b1, 1'b1, 1, 1'b0);
        n_cmp++; if (dout !== 8'hAD) begin n_err++; $display("FAIL msb_dout: got %h want ad", dout); end
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL msb_valid: got %b want 1", dout_valid); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if ({dout, dout_valid, busy} !== {8'hAD, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL msb_idle_hold: got %h/%b/%b want ad/1/0", dout, dout_valid, busy); end
        consume();
    endtask

    task automatic test_frame_err();
        send_frame(8'h77, 1'b0, 1'b0, 0, 1'b0);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_pulse: got %b want 1", frame_err); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL ferr_valid: got %b want 0", dout_valid); end
        n_cmp++; if (dout !== 8'hAD) begin n_err++; $display("FAIL ferr_dout: got %h want ad", dout); end
        @(posedge clk);
        #1;
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_one_cycle: got %b want 0", frame_err); end
        send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
        n_cmp++; if ({dout, dout_valid} !== {8'h3C, 1'b1}) begin
            n_err++; $display("FAIL ferr_next: got %h/%b want 3c/1", dout, dout_valid); end
        consume();
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", overrun); end
        n_cmp++; if ({dout, dout_valid} !== {8'h11, 1'b1}) begin
            n_err++; $display("FAIL ovr_hold: got %h/%b want 11/1", dout, dout_valid); end
        @(posedge clk);
        #1;
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_one_cycle: got %b want 0", overrun); end
        consume();
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL ovr_consume: got %b want 0", dout_valid); end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1);
        n_cmp++; if ({dout, dout_valid} !== {8'h22, 1'b1}) begin
            n_err++; $display("FAIL b2b_replace: got %h/%b want 22/1", dout, dout_valid); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_no_overrun: got %b want 0", overrun); end
        consume();
    endtask

    task automatic test_reset_mid_frame();
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 0);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({dout, dout_valid, busy, frame_err, overrun} !== 12'h000) begin
            n_err++; $display("FAIL midrst_outputs: got %h/%b%b%b%b want 00/0000",
                              dout, dout_valid, busy, frame_err, overrun); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0);
        n_cmp++; if ({dout, dout_valid} !== {8'h5A, 1'b1}) begin
            n_err++; $display("FAIL midrst_frame: got %h/%b want 5a/1", dout, dout_valid); end
        n_cmp++; if ({frame_err, overrun} !== 2'b00) begin
            n_err++; $display("FAIL midrst_pulses: got %b want 00", {frame_err, overrun}); end
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_gapped();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
